// File: rtl/opc5ls_bus_pkg.sv
// opc5ls_bus_pkg: bus owner and arbiter state encodings shared by the opc5ls memory arbiter
package opc5ls_bus_pkg;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;
  typedef enum logic {ARB, WAIT} arb_state_t;
endpackage

// File: rtl/opc5ls_mem_arbiter.sv
// opc5ls_mem_arbiter: shares one async-read/sync-write memory port between the opc5ls CPU and a DMA master
//   cpu_*   : CPU bus pins; cpu_clken stalls the CPU while DMA owns the bus or wait states elapse
//   dma_*   : DMA master, dma_req held until the one-cycle dma_ack pulse
//   mem_*   : system RAM port, mem_we sampled at clk rise, mem_rdata combinational
//   reset_b : asynchronous active-low reset
module opc5ls_mem_arbiter
  import opc5ls_bus_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int MAX_BURST   = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_rnw,
  input  logic              cpu_vpa,
  input  logic              cpu_vda,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_clken,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_rnw,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int BW = $clog2(MAX_BURST + 1);
  arb_state_t state;
  owner_t owner_q, arb_own, own;
  logic [BW-1:0] burst_cnt;
  logic cpu_req, any_req, in_arb, fin, last, clr;
  assign cpu_req = cpu_vpa | cpu_vda;
  assign cpu_din = mem_rdata;
  assign dma_rdata = mem_rdata;
  always_comb begin
    any_req = cpu_req | dma_req;
    // a saturated burst counter forces one CPU slot so DMA cannot starve the CPU
    arb_own = (burst_cnt == BW'(MAX_BURST) && cpu_req) ? OWN_CPU : dma_req ? OWN_DMA : OWN_CPU;
    in_arb = state == ARB;
    own = in_arb ? arb_own : owner_q;
    fin = in_arb ? (any_req && (WAIT_STATES == 0)) : last;
    clr = (in_arb && !any_req) || (fin && own == OWN_CPU);
    cpu_clken = reset_b && clr;
    dma_ack = reset_b && fin && own == OWN_DMA;
    mem_we = reset_b && fin && (own == OWN_DMA ? !dma_rnw : !cpu_rnw);
    mem_addr = own == OWN_DMA ? dma_addr : cpu_address;
    mem_wdata = own == OWN_DMA ? dma_wdata : cpu_dout;
  end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) burst_cnt <= '0;
    else if (clr) burst_cnt <= '0;
    else if (fin && burst_cnt != BW'(MAX_BURST)) burst_cnt <= burst_cnt + 1'b1;
  if (WAIT_STATES == 0) begin : g_nowait
    assign state = ARB;
    assign owner_q = OWN_CPU;
    assign last = 1'b0;
  end else begin : g_wait
    localparam int WW = $clog2(WAIT_STATES + 1);
    arb_state_t state_d;
    logic [WW-1:0] wcnt;
    always_comb begin
      state_d = state;
      if (in_arb && any_req) state_d = WAIT;
      else if (last) state_d = ARB;
    end
    always_ff @(posedge clk or negedge reset_b)
      if (!reset_b) begin
        state <= ARB;
        owner_q <= OWN_CPU;
        wcnt <= '0;
      end else begin
        state <= state_d;
        if (in_arb && any_req) begin
          owner_q <= arb_own;
          wcnt <= WW'(1);
        end else if (!in_arb) wcnt <= wcnt + 1'b1;
      end
    assign last = !in_arb && wcnt == WW'(WAIT_STATES);
  end
endmodule
